// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-owner tags and
// the starvation counter width.
package dmem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic {
    CORE_PRI   = 1'b0,
    HOST_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter. at_max looks at the value being loaded this
// edge so the arbiter can schedule the forced host slot for the very next cycle.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // NOTE: assign a default first so every path writes cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign at_max = (cnt_d == MAX_C);

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MIPS core (priority) and
// the test host, with a starvation-forced host slot and tagged read returns.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  rd_owner_e  rd_owner_q, rd_owner_d;
  logic       core_gnt;
  logic       at_max;

  // Byte-lane bits are not used by a word-addressed memory.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{core_addr[1:0], host_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CORE_PRI;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_PRI:   if (at_max) state_d = HOST_FORCE;
      HOST_FORCE: state_d = CORE_PRI;
    endcase
  end

  // Grants are gated by reset so every strobe is low while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (reset) begin
      case (state_q)
        CORE_PRI: begin
          core_gnt = core_req;
          host_gnt = host_req & ~core_req;
        end
        HOST_FORCE: begin
          if (host_req) host_gnt = 1'b1;
          else          core_gnt = core_req;
        end
      endcase
    end
  end

  assign core_stall = reset & core_req & ~core_gnt;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (host_req & ~host_gnt),
    .clr   (host_gnt | ~host_req | (state_q == HOST_FORCE)),
    .at_max(at_max)
  );

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rd_owner_d = OWN_NONE;
    if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr[AW-1:2];
      mem_wdata = core_wdata;
      if (!core_we) rd_owner_d = OWN_CORE;
    end else if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr[AW-1:2];
      mem_wdata = host_wdata;
      if (!host_we) rd_owner_d = OWN_HOST;
    end
  end

  assign core_rvalid = (rd_owner_q == OWN_CORE);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, plus a
// cycle-by-cycle comparison against a rule-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata;
  logic          core_stall, core_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Environment memory, driven only by the DUT's memory port.
  logic [31:0] env_mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[5:0]];
    end
  end

  // Reference model: host wins when the core is idle or after SM straight losses.
  int          lost = 0;
  int          m_owner = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_mem [64];

  function automatic logic m_hgnt();
    return reset && host_req && (!core_req || lost >= SM);
  endfunction

  function automatic logic m_cgnt();
    return reset && core_req && !m_hgnt();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost    <= 0;
      m_owner <= 0;
      m_rd    <= '0;
    end else begin
      if (host_req && !m_hgnt()) lost <= (lost < SM) ? lost + 1 : SM;
      else                       lost <= 0;
      m_owner <= 0;
      if (m_cgnt()) begin
        if (core_we) m_mem[core_addr[7:2]] <= core_wdata;
        else begin
          m_owner <= 1;
          m_rd    <= m_mem[core_addr[7:2]];
        end
      end else if (m_hgnt()) begin
        if (host_we) m_mem[host_addr[7:2]] <= host_wdata;
        else begin
          m_owner <= 2;
          m_rd    <= m_mem[host_addr[7:2]];
        end
      end
    end
  end

  logic        e_cg, e_hg;
  logic [29:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_we;

  always @(negedge clk) begin
    e_hg    = m_hgnt();
    e_cg    = m_cgnt();
    e_addr  = e_cg ? core_addr[31:2] : (e_hg ? host_addr[31:2] : '0);
    e_wdata = e_cg ? core_wdata : (e_hg ? host_wdata : '0);
    e_we    = e_cg ? core_we : (e_hg ? host_we : 1'b0);
    check("model host_gnt",    host_gnt,    e_hg);
    check("model core_stall",  core_stall,  reset && core_req && !e_cg);
    check("model mem_en",      mem_en,      e_cg || e_hg);
    check("model mem_we",      mem_we,      e_we);
    check("model mem_addr",    mem_addr,    e_addr);
    check("model mem_wdata",   mem_wdata,   e_wdata);
    check("model core_rvalid", core_rvalid, reset && m_owner == 1);
    check("model host_rvalid", host_rvalid, reset && m_owner == 2);
    check("model core_rdata",  core_rdata,  (reset && m_owner == 1) ? m_rd : 32'h0);
    check("model host_rdata",  host_rdata,  (reset && m_owner == 2) ? m_rd : 32'h0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic idle();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_host(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'hA000_0000 + i;
      m_mem[i]   = 32'hA000_0000 + i;
    end
    env_mem[20] = 32'h1234;
    m_mem[20]   = 32'h1234;

    // Requests asserted during reset must not reach the memory.
    reset = 1'b0;
    set_core(1'b1, 1'b0, 32'd8, 32'h0);
    set_host(1'b1, 1'b0, 32'd12, 32'h0);
    repeat (2) @(posedge clk);
    mid();
    check("rst host_gnt",   host_gnt,   0);
    check("rst core_stall", core_stall, 0);
    check("rst mem_en",     mem_en,     0);
    check("rst mem_addr",   mem_addr,   0);
    cyc();
    reset = 1'b1;
    idle();

    // Core write only.
    cyc();
    set_core(1'b1, 1'b1, 32'd84, 32'd7);
    mid();
    check("wr mem_en",     mem_en,     1);
    check("wr mem_we",     mem_we,     1);
    check("wr mem_addr",   mem_addr,   21);
    check("wr mem_wdata",  mem_wdata,  7);
    check("wr core_stall", core_stall, 0);
    cyc();
    idle();
    mid();
    check("wr core_rvalid", core_rvalid, 0);
    check("wr host_rvalid", host_rvalid, 0);

    // Host read only.
    cyc();
    set_host(1'b1, 1'b0, 32'd80, 32'h0);
    mid();
    check("hrd host_gnt", host_gnt, 1);
    cyc();
    idle();
    mid();
    check("hrd host_rvalid", host_rvalid, 1);
    check("hrd host_rdata",  host_rdata,  32'h1234);
    check("hrd core_rvalid", core_rvalid, 0);

    // Continuous contention: host gets every fifth slot.
    cyc();
    set_core(1'b1, 1'b0, 32'd8, 32'h0);
    set_host(1'b1, 1'b0, 32'd12, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) cyc();
      mid();
      check($sformatf("starve host_gnt c%0d", k),   host_gnt,   (k % 5) == 0);
      check($sformatf("starve core_stall c%0d", k), core_stall, (k % 5) == 0);
    end
    cyc();
    idle();

    // Interleaved reads from alternating requesters.
    cyc();
    set_core(1'b1, 1'b0, 32'd0, 32'h0);
    mid();
    check("il core grant", mem_en && !core_stall, 1);
    cyc();
    idle();
    set_host(1'b1, 1'b0, 32'd4, 32'h0);
    mid();
    check("il core_rvalid", core_rvalid, 1);
    check("il core_rdata",  core_rdata,  32'hA000_0000);
    check("il host_rvalid", host_rvalid, 0);
    check("il host_gnt",    host_gnt,    1);
    cyc();
    idle();
    mid();
    check("il host_rvalid2", host_rvalid, 1);
    check("il host_rdata",   host_rdata,  32'hA000_0001);
    check("il core_rvalid2", core_rvalid, 0);

    // Host withdraws in the cycle it would have been forced.
    cyc();
    set_core(1'b1, 1'b1, 32'd16, 32'h55);
    set_host(1'b1, 1'b1, 32'd24, 32'h66);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) cyc();
      mid();
      check($sformatf("drop host_gnt c%0d", k), host_gnt, 0);
    end
    cyc();
    host_req = 1'b0;
    mid();
    check("drop core_stall", core_stall, 0);
    check("drop host_gnt",   host_gnt,   0);
    check("drop mem_addr",   mem_addr,   4);
    cyc();
    host_req = 1'b1;
    mid();
    check("drop after host_gnt",   host_gnt,   0);
    check("drop after core_stall", core_stall, 0);
    cyc();
    idle();

    // Reset while a host read is in flight.
    cyc();
    set_host(1'b1, 1'b0, 32'd80, 32'h0);
    mid();
    check("rmr host_gnt", host_gnt, 1);
    #2;
    reset    = 1'b0;
    core_req = 1'b1;
    #1;
    check("rmr async host_gnt",   host_gnt,   0);
    check("rmr async mem_en",     mem_en,     0);
    check("rmr async mem_addr",   mem_addr,   0);
    check("rmr async core_stall", core_stall, 0);
    check("rmr async host_rdata", host_rdata, 0);
    cyc();
    reset = 1'b1;
    set_core(1'b1, 1'b0, 32'd8, 32'h0);
    set_host(1'b1, 1'b0, 32'd12, 32'h0);
    mid();
    check("rmr host_rvalid",  host_rvalid, 0);
    check("rmr host_gnt",     host_gnt,    0);
    check("rmr core_stall",   core_stall,  0);
    cyc();
    idle();
    mid();
    check("rmr core_rvalid",  core_rvalid, 1);
    check("rmr core_rdata",   core_rdata,  32'hA000_0002);
    check("rmr host_rvalid2", host_rvalid, 0);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipelined MIPS core's data port and a host port used for matrix load/dump during test. The core has priority; a starvation counter guarantees the host a slot. Read data returns one cycle later and is routed back to the requester that issued the read. The block sits between the core's memory stage and the data memory inside `top`.

## Interface
- `AW`, 32, byte-address width of both requester ports
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive cycles a pending host request may lose to the core before it is forced through (1..15)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core memory access this cycle
- `core_we`  in  1  core access is a write
- `core_addr`  in  AW  core byte address
- `core_wdata`  in  DW  core write data
- `core_stall`  out  1  core access not accepted; core holds request and fields stable
- `core_rdata`  out  DW  read data for the core
- `core_rvalid`  out  1  `core_rdata` valid
- `host_req`  in  1  host access pending; held until granted
- `host_we`  in  1  host access is a write
- `host_addr`  in  AW  host byte address
- `host_wdata`  in  DW  host write data
- `host_gnt`  out  1  host access accepted this cycle
- `host_rdata`  out  DW  read data for the host
- `host_rvalid`  out  1  `host_rdata` valid
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW-2  word address, equal to `addr[AW-1:2]`; byte bits ignored
- `mem_wdata`  out  DW  write data
- `mem_rdata`  in  DW  synchronous read data, valid one cycle after `mem_en & ~mem_we`

## Operation
- The FSM has two states: CORE_PRI (reset state) and HOST_FORCE.
- In CORE_PRI, `core_req` wins. The host is granted only when `core_req`=0.
- The starvation counter `starve_cnt` increments each cycle `host_req & ~host_gnt` holds. It clears on `host_gnt` or `host_req`=0. It saturates at STARVE_MAX.
- When `starve_cnt` reaches STARVE_MAX, the next state is HOST_FORCE.
- HOST_FORCE lasts exactly one cycle. The host is granted, and `core_stall` = `core_req`. The state then returns to CORE_PRI and the counter clears.
- If `host_req` drops while the FSM is in HOST_FORCE, the core is granted normally that cycle.
- The mem port is driven combinationally from the granted requester. When nothing is granted: `mem_en`=0, `mem_we`=0, and addr/wdata are 0.
- The owner tag register `rd_owner` ∈ {NONE, CORE, HOST} is loaded each cycle with the owner of a granted read, or NONE otherwise.
- Next cycle: `core_rvalid` = (`rd_owner`==CORE) and `host_rvalid` = (`rd_owner`==HOST).
- Both `core_rdata` and `host_rdata` carry `mem_rdata` when their rvalid is 1, and are 0 otherwise.
- Writes produce no rvalid.

## Timing
- Grant, `core_stall`, and all mem outputs are combinational within the request cycle: zero-cycle issue latency.
- Read latency is 1 cycle, from grant to rvalid.
- Back-to-back reads from alternating requesters are supported every cycle, with no bubbles.
- Reset (`reset`=0) is asynchronous:
  - FSM → CORE_PRI, `starve_cnt` → 0, `rd_owner` → NONE.
  - `core_stall`, `host_gnt`, `mem_en`, `mem_we`, and both rvalids are forced 0 while reset is low.
  - All data outputs are 0.
- An outstanding read in flight at reset is dropped: no rvalid after reset releases.
- Simultaneous `core_req` and `host_req` with `starve_cnt` < STARVE_MAX: core granted, counter increments.
- Counter saturation never wraps.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_e` {CORE_PRI, HOST_FORCE}
  - `rd_owner_e` {OWN_NONE, OWN_CORE, OWN_HOST}
  - `STARVE_W` = 4
- Sub-module `arb_starve_ctr`: a saturating counter with `inc`, `clr`, and `at_max` output, parameterised by STARVE_MAX.
- Everything else lives in `dmem_arbiter`.

## Test plan
- **Core write only.** Stimulus: `core_req`=1, `core_we`=1, addr 84, data 7. Required: same cycle `mem_en`=1, `mem_we`=1, `mem_addr`=21, `mem_wdata`=7, `core_stall`=0, no rvalid next cycle.
- **Host read only.** Stimulus: host read of addr 80 with memory word 20 = 0x1234. Required: `host_gnt`=1 that cycle; next cycle `host_rvalid`=1, `host_rdata`=0x1234, `core_rvalid`=0.
- **Starvation, STARVE_MAX=4.** Stimulus: core and host requesting continuously. Required: core granted 4 cycles, host granted on the 5th with `core_stall`=1 only on that cycle, then the pattern repeats.
- **Interleaved reads.** Stimulus: core reads addr 0 in cycle n; host reads addr 4 in cycle n+1. Required: `core_rvalid` in n+1 with word 0; `host_rvalid` in n+2 with word 1; never both high.
- **Reset mid-read.** Stimulus: host read granted, then `reset` pulled low before the next edge. Required: all outputs 0 immediately; no `host_rvalid` after release; first post-reset contention grants the core.
- **Host drops in HOST_FORCE.** Stimulus: `host_req` deasserts in the forced cycle. Required: core granted, `core_stall`=0, FSM returns to CORE_PRI.
